// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler sharing one serial transmitter between NUM_REQ byte
// requesters. An owner keeps the line until it sends a byte flagged last, or
// until it idles in the middle of a packet for HOLD_TIMEOUT cycles.
module serial_tx_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned HOLD_TIMEOUT = 1000
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          tx_start_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_done_i,
  output logic                          grant_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_index_o,
  output logic                          lock_timeout_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  // Keep at least one bit so HOLD_TIMEOUT=0 still elaborates.
  localparam int unsigned CntW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        last_grant_q, last_grant_d;
  logic [IdxW-1:0]        grant_index_q, grant_index_d;
  logic                   grant_valid_q, grant_valid_d;
  logic                   lock_q, lock_d;
  logic                   tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   lock_timeout_q, lock_timeout_d;
  logic [CntW-1:0]        hold_cnt_q, hold_cnt_d;

  logic                   win_found;
  logic [IdxW-1:0]        win_idx;
  logic [IdxW-1:0]        scan_idx;
  logic [IdxW-1:0]        sel_idx;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   accept;

  // Round-robin winner: scan far-to-near so the nearest valid index after
  // last_grant is the one that sticks.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = IdxW'((32'(last_grant_q) + 32'(k)) % NUM_REQ);
      if (req_valid_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Ready depends only on state, owner/winner and valid, never on data.
  always_comb begin
    req_ready_o = '0;
    if (state_q == StIdle && win_found) begin
      req_ready_o[win_idx] = 1'b1;
    end else if (state_q == StHold) begin
      req_ready_o[grant_index_q] = req_valid_i[grant_index_q];
    end
  end

  assign accept   = |(req_valid_i & req_ready_o);
  assign sel_idx  = (state_q == StIdle) ? win_idx : grant_index_q;
  assign sel_data = req_data_i[32'(sel_idx) * DATA_WIDTH +: DATA_WIDTH];

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_index_d  = grant_index_q;
    grant_valid_d  = grant_valid_q;
    lock_d         = lock_q;
    tx_data_d      = tx_data_q;
    hold_cnt_d     = hold_cnt_q;
    tx_start_d     = 1'b0;
    lock_timeout_d = 1'b0;
    unique case (state_q)
      StIdle, StHold: begin
        if (accept) begin
          tx_data_d     = sel_data;
          tx_start_d    = 1'b1;
          grant_index_d = sel_idx;
          grant_valid_d = 1'b1;
          lock_d        = ~req_last_i[sel_idx];
          state_d       = StWait;
        end else if (state_q == StHold) begin
          if (HOLD_TIMEOUT != 0 && hold_cnt_q == CntLast) begin
            lock_timeout_d = 1'b1;
            last_grant_d   = grant_index_q;
            grant_valid_d  = 1'b0;
            state_d        = StIdle;
          end else if (hold_cnt_q != CntMax) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      StWait: begin
        // A done coincident with our own start pulse belongs to an older frame.
        if (tx_done_i && !tx_start_q) begin
          if (lock_q) begin
            hold_cnt_d = '0;
            state_d    = StHold;
          end else begin
            last_grant_d  = grant_index_q;
            grant_valid_d = 1'b0;
            state_d       = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      last_grant_q   <= IdxW'(NUM_REQ - 1);
      grant_index_q  <= '0;
      grant_valid_q  <= 1'b0;
      lock_q         <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      lock_timeout_q <= 1'b0;
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_index_q  <= grant_index_d;
      grant_valid_q  <= grant_valid_d;
      lock_q         <= lock_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      lock_timeout_q <= lock_timeout_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  assign tx_start_o     = tx_start_q;
  assign tx_data_o      = tx_data_q;
  assign grant_valid_o  = grant_valid_q;
  assign grant_index_o  = grant_index_q;
  assign lock_timeout_o = lock_timeout_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed bench for serial_tx_scheduler (4 requesters, 8-bit bytes,
// hold timeout of 8 cycles). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_serial_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [3:0] req_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       grant_valid;
  logic [1:0] grant_index;
  logic       lock_timeout;
  logic [7:0] d0, d1, d2, d3;
  logic [31:0] req_data;

  int checks   = 0;
  int failures = 0;

  assign req_data = {d3, d2, d1, d0};

  always #5 clk = ~clk;

  serial_tx_scheduler #(
    .NUM_REQ     (4),
    .DATA_WIDTH  (8),
    .HOLD_TIMEOUT(8)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_last_i    (req_last),
    .req_ready_o   (req_ready),
    .tx_start_o    (tx_start),
    .tx_data_o     (tx_data),
    .tx_done_i     (tx_done),
    .grant_valid_o (grant_valid),
    .grant_index_o (grant_index),
    .lock_timeout_o(lock_timeout)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_last = '0; tx_done = 1'b0;
    d0 = 8'hA0; d1 = 8'hA1; d2 = 8'hA2; d3 = 8'hA3;
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0) begin failures++;
      $display("FAIL reset_tx_start got=%0d exp=0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++;
      $display("FAIL reset_tx_data got=%0h exp=0", tx_data); end
    checks++; if (grant_valid !== 1'b0) begin failures++;
      $display("FAIL reset_grant_valid got=%0d exp=0", grant_valid); end
    checks++; if (grant_index !== 2'd0) begin failures++;
      $display("FAIL reset_grant_index got=%0d exp=0", grant_index); end
    checks++; if (lock_timeout !== 1'b0) begin failures++;
      $display("FAIL reset_lock_timeout got=%0d exp=0", lock_timeout); end
    checks++; if (req_ready !== 4'b0000) begin failures++;
      $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
  endtask

  // req_valid=1010, all single-byte packets: grants alternate 1,3,1,3.
  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    exp_g = '{2'd1, 2'd3, 2'd1, 2'd3};
    req_valid = 4'b1010; req_last = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << exp_g[i])) begin failures++;
        $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, 4'b0001 << exp_g[i]); end
      step();
      checks++; if (tx_start !== 1'b1) begin failures++;
        $display("FAIL rr_tx_start[%0d] got=%0d exp=1", i, tx_start); end
      checks++; if (grant_index !== exp_g[i]) begin failures++;
        $display("FAIL rr_grant_index[%0d] got=%0d exp=%0d", i, grant_index, exp_g[i]); end
      checks++; if (tx_data !== 8'(8'hA0 + exp_g[i])) begin failures++;
        $display("FAIL rr_tx_data[%0d] got=%0h exp=%0h", i, tx_data, 8'(8'hA0 + exp_g[i])); end
      checks++; if (grant_valid !== 1'b1 || req_ready !== 4'b0000) begin failures++;
        $display("FAIL rr_wait[%0d] got gv=%0d rdy=%b exp gv=1 rdy=0000", i, grant_valid,
                 req_ready); end
      step();
      checks++; if (tx_start !== 1'b0) begin failures++;
        $display("FAIL rr_start_pulse[%0d] got=%0d exp=0", i, tx_start); end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      checks++; if (grant_valid !== 1'b0) begin failures++;
        $display("FAIL rr_release[%0d] got=%0d exp=0", i, grant_valid); end
    end
    req_valid = '0;
  endtask

  // Requester 2 sends 3 locked bytes while requester 0 waits.
  task automatic test_packet_lock();
    req_valid = 4'b0100; req_last = 4'b0000; d2 = 8'h21;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++;
      $display("FAIL pkt_ready0 got=%b exp=0100", req_ready); end
    step();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h21 || grant_index !== 2'd2) begin
      failures++;
      $display("FAIL pkt_byte1 got start=%0d data=%0h idx=%0d exp 1/21/2", tx_start, tx_data,
               grant_index); end
    req_valid = 4'b0101; d2 = 8'h22;
    step();
    tx_done = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++;
      $display("FAIL pkt_wait_ready got=%b exp=0000", req_ready); end
    step();
    tx_done = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100 || grant_valid !== 1'b1) begin failures++;
      $display("FAIL pkt_hold1 got rdy=%b gv=%0d exp 0100/1", req_ready, grant_valid); end
    step();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h22) begin failures++;
      $display("FAIL pkt_byte2 got start=%0d data=%0h exp 1/22", tx_start, tx_data); end
    d2 = 8'h23; req_last = 4'b0101;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++;
      $display("FAIL pkt_hold2 got=%b exp=0100", req_ready); end
    step();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h23 || grant_index !== 2'd2) begin
      failures++;
      $display("FAIL pkt_byte3 got start=%0d data=%0h idx=%0d exp 1/23/2", tx_start, tx_data,
               grant_index); end
    req_valid = 4'b0001;
    step();
    tx_done = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++;
      $display("FAIL pkt_wait3_ready got=%b exp=0000", req_ready); end
    step();
    tx_done = 1'b0;
    #1;
    checks++; if (grant_valid !== 1'b0 || req_ready !== 4'b0001) begin failures++;
      $display("FAIL pkt_release got gv=%0d rdy=%b exp 0/0001", grant_valid, req_ready); end
    step();
    req_valid = '0;
    checks++; if (tx_start !== 1'b1 || grant_index !== 2'd0 || tx_data !== 8'hA0) begin
      failures++;
      $display("FAIL pkt_next got start=%0d idx=%0d data=%0h exp 1/0/a0", tx_start,
               grant_index, tx_data); end
    d2 = 8'hA2;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (grant_valid !== 1'b0) begin failures++;
      $display("FAIL pkt_done got=%0d exp=0", grant_valid); end
  endtask

  // Owner 1 stalls mid-packet; the lock is released 8 cycles into HOLD.
  task automatic test_timeout();
    req_valid = 4'b0010; req_last = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++;
      $display("FAIL to_ready got=%b exp=0010", req_ready); end
    step();
    checks++; if (tx_start !== 1'b1 || grant_index !== 2'd1) begin failures++;
      $display("FAIL to_grant got start=%0d idx=%0d exp 1/1", tx_start, grant_index); end
    req_valid = 4'b0101; req_last = 4'b1111;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (lock_timeout !== 1'b0 || grant_valid !== 1'b1 || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL to_hold[%0d] got lt=%0d gv=%0d rdy=%b exp 0/1/0000", k, lock_timeout,
                 grant_valid, req_ready); end
      step();
    end
    #1;
    checks++; if (lock_timeout !== 1'b1 || grant_valid !== 1'b0) begin failures++;
      $display("FAIL to_pulse got lt=%0d gv=%0d exp 1/0", lock_timeout, grant_valid); end
    checks++; if (req_ready !== 4'b0100) begin failures++;
      $display("FAIL to_next_winner got=%b exp=0100", req_ready); end
    step();
    req_valid = '0;
    checks++; if (lock_timeout !== 1'b0 || tx_start !== 1'b1 || grant_index !== 2'd2) begin
      failures++;
      $display("FAIL to_after got lt=%0d start=%0d idx=%0d exp 0/1/2", lock_timeout, tx_start,
               grant_index); end
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (grant_valid !== 1'b0) begin failures++;
      $display("FAIL to_done got=%0d exp=0", grant_valid); end
  endtask

  // Owner 3 resumes exactly on the expiry cycle: the accept wins.
  task automatic test_accept_at_expiry();
    req_valid = 4'b1000; req_last = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++;
      $display("FAIL ex_ready got=%b exp=1000", req_ready); end
    step();
    checks++; if (tx_start !== 1'b1 || grant_index !== 2'd3) begin failures++;
      $display("FAIL ex_grant got start=%0d idx=%0d exp 1/3", tx_start, grant_index); end
    req_valid = '0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      checks++; if (lock_timeout !== 1'b0) begin failures++;
        $display("FAIL ex_hold[%0d] got=%0d exp=0", k, lock_timeout); end
      step();
    end
    req_valid = 4'b1000; req_last = 4'b1000; d3 = 8'h3C;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++;
      $display("FAIL ex_last_ready got=%b exp=1000", req_ready); end
    step();
    checks++; if (lock_timeout !== 1'b0 || tx_start !== 1'b1 || tx_data !== 8'h3C) begin
      failures++;
      $display("FAIL ex_accept got lt=%0d start=%0d data=%0h exp 0/1/3c", lock_timeout,
               tx_start, tx_data); end
    checks++; if (grant_valid !== 1'b1 || req_ready !== 4'b0000) begin failures++;
      $display("FAIL ex_wait got gv=%0d rdy=%b exp 1/0000", grant_valid, req_ready); end
    req_valid = '0;
    step();
    checks++; if (lock_timeout !== 1'b0) begin failures++;
      $display("FAIL ex_no_pulse got=%0d exp=0", lock_timeout); end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (grant_valid !== 1'b0) begin failures++;
      $display("FAIL ex_done got=%0d exp=0", grant_valid); end
    d3 = 8'hA3;
  endtask

  // tx_done coincident with tx_start is ignored.
  task automatic test_coincident_done();
    req_valid = 4'b0001; req_last = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++;
      $display("FAIL co_ready got=%b exp=0001", req_ready); end
    step();
    checks++; if (tx_start !== 1'b1 || grant_index !== 2'd0) begin failures++;
      $display("FAIL co_grant got start=%0d idx=%0d exp 1/0", tx_start, grant_index); end
    tx_done = 1'b1; req_valid = '0;
    step();
    tx_done = 1'b0;
    checks++; if (grant_valid !== 1'b1 || tx_start !== 1'b0) begin failures++;
      $display("FAIL co_ignored got gv=%0d start=%0d exp 1/0", grant_valid, tx_start); end
    step();
    checks++; if (grant_valid !== 1'b1) begin failures++;
      $display("FAIL co_still_wait got=%0d exp=1", grant_valid); end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (grant_valid !== 1'b0) begin failures++;
      $display("FAIL co_done got=%0d exp=0", grant_valid); end
  endtask

  // Reset during WAIT abandons the byte and restores requester 0 priority.
  task automatic test_reset_mid();
    req_valid = 4'b0010; req_last = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++;
      $display("FAIL rm_ready got=%b exp=0010", req_ready); end
    step();
    checks++; if (tx_start !== 1'b1 || grant_index !== 2'd1) begin failures++;
      $display("FAIL rm_grant got start=%0d idx=%0d exp 1/1", tx_start, grant_index); end
    req_valid = '0; reset = 1'b1;
    step();
    reset = 1'b0; tx_done = 1'b1;
    #1;
    checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00 || lock_timeout !== 1'b0) begin
      failures++;
      $display("FAIL rm_outputs got start=%0d data=%0h lt=%0d exp 0/0/0", tx_start, tx_data,
               lock_timeout); end
    checks++; if (grant_valid !== 1'b0 || grant_index !== 2'd0 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL rm_grant_regs got gv=%0d idx=%0d rdy=%b exp 0/0/0000", grant_valid,
               grant_index, req_ready); end
    step();
    tx_done = 1'b0;
    checks++; if (grant_valid !== 1'b0 || tx_start !== 1'b0) begin failures++;
      $display("FAIL rm_idle got gv=%0d start=%0d exp 0/0", grant_valid, tx_start); end
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++;
      $display("FAIL rm_priority got=%b exp=0001", req_ready); end
    step();
    req_valid = '0;
    checks++; if (tx_start !== 1'b1 || grant_index !== 2'd0 || tx_data !== 8'hA0) begin
      failures++;
      $display("FAIL rm_regrant got start=%0d idx=%0d data=%0h exp 1/0/a0", tx_start,
               grant_index, tx_data); end
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (grant_valid !== 1'b0) begin failures++;
      $display("FAIL rm_done got=%0d exp=0", grant_valid); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_timeout();
    test_accept_at_expiry();
    test_coincident_done();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
